hack_word_tx: RTL

HACK_WORD_TX -- requirements
Module: hack_word_tx

---
 rtl/hack_word_tx.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/hack_word_tx.sv
// Word-to-serial transmitter: sends a WIDTH-bit word as WIDTH/8 UART-style byte
// frames (start 0, 8 data bits LSB first, stop 1), most-significant byte first.
module hack_word_tx #(
    parameter int WIDTH        = 16,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    output logic             ready,
    output logic             tx,
    output logic [1:0]       state_o
);

    // Handshake: a word is accepted on a rising edge where load=1 and ready=1;
    // load while ready=0 is dropped, nothing is queued.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int NBYTES = WIDTH / 8;
    localparam int CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BYTE_W-1:0] BYTE_MAX = BYTE_W'(NBYTES - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         bit_q, bit_d;
    logic [BYTE_W-1:0]  byte_q, byte_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic               tx_q, tx_d;
    logic               ready_q, ready_d;
    logic               bit_end;
    logic [7:0]         cur_byte;

    assign bit_end = (cnt_q == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        shift_d = shift_q;
        case (state_q)
            IDLE: begin
                if (load && ready_q) begin
                    state_d = START;
                    cnt_d   = '0;
                    bit_d   = '0;
                    byte_d  = '0;
                    shift_d = in;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (byte_q == BYTE_MAX) begin
                        state_d = IDLE;
                        byte_d  = '0;
                    end else begin
                        // Next byte starts immediately; bring it to the top of the register.
                        state_d = START;
                        byte_d  = byte_q + 1'b1;
                        shift_d = shift_q << 8;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // tx and ready are registered from the next state so they change on the same edge as the state.
    always_comb begin
        cur_byte = shift_d[WIDTH-1 -: 8];
        tx_d     = 1'b1;
        ready_d  = 1'b0;
        case (state_d)
            IDLE:    ready_d = 1'b1;
            START:   tx_d    = 1'b0;
            DATA:    tx_d    = cur_byte[bit_d];
            STOP:    tx_d    = 1'b1;
            default: tx_d    = 1'b1;
        endcase
    end

    assign tx      = tx_q;
    assign ready   = ready_q;
    assign state_o = state_q;

endmodule
